// File: rtl/menu_fade_ctrl.sv
// menu_fade_ctrl: menu screen fade sequencer and palette colour scaler.
// Optional key-colour bypass: define MENU_FADE_KEY_BYPASS_EN.
module menu_fade_ctrl #(
    parameter int         FRAMES_PER_STEP = 2,
    parameter logic [3:0] KEY_INDEX       = 4'd0
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       vsync_pulse,
    input  logic       fade_in_req,
    input  logic       fade_out_req,
    input  logic [3:0] pix_index,
    output logic [3:0] pal_index,
    input  logic [3:0] pal_red,
    input  logic [3:0] pal_green,
    input  logic [3:0] pal_blue,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic [4:0] level,
    output logic       busy,
    output logic       done
);

    localparam int CW = (FRAMES_PER_STEP > 1) ?
                        $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAMES_PER_STEP - 1);

    typedef enum logic [1:0] {
        BLACK    = 2'd0,
        FADE_IN  = 2'd1,
        VISIBLE  = 2'd2,
        FADE_OUT = 2'd3
    } state_t;

    state_t          state;
    logic [CW-1:0]   fcnt;
    logic            go_in;
    logic            go_out;
    logic            step;
    logic [8:0]      pr;
    logic [8:0]      pg;
    logic [8:0]      pb;
    logic [3:0]      sr;
    logic [3:0]      sg;
    logic [3:0]      sb;
    logic [3:0]      nr;
    logic [3:0]      ng;
    logic [3:0]      nb;
    logic [14:0]     unused_bits;

    // Simultaneous requests cancel each other out.
    assign go_in  = fade_in_req && !fade_out_req;
    assign go_out = fade_out_req && !fade_in_req;
    assign step   = vsync_pulse && (fcnt == CNT_LAST);

    assign pal_index = pix_index;

    // Scale each channel by level/16 at 9-bit width.
    assign pr = {5'd0, pal_red}   * {4'd0, level};
    assign pg = {5'd0, pal_green} * {4'd0, level};
    assign pb = {5'd0, pal_blue}  * {4'd0, level};
    assign sr = pr[7:4];
    assign sg = pg[7:4];
    assign sb = pb[7:4];
    assign unused_bits = {pr[8], pr[3:0], pg[8], pg[3:0],
                          pb[8], pb[3:0]};

`ifdef MENU_FADE_KEY_BYPASS_EN
    logic key_hit;
    assign key_hit = (pix_index == KEY_INDEX);
    // Key colour keeps full brightness throughout a fade.
    assign nr = key_hit ? pal_red   : sr;
    assign ng = key_hit ? pal_green : sg;
    assign nb = key_hit ? pal_blue  : sb;
`else
    logic unused_key;
    assign unused_key = (pix_index == KEY_INDEX);
    assign nr = sr;
    assign ng = sg;
    assign nb = sb;
`endif

    // Fade state machine, frame counter and brightness level.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= BLACK;
            level <= 5'd0;
            fcnt  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                BLACK: begin
                    if (go_in) begin
                        state <= FADE_IN;
                        fcnt  <= '0;
                        busy  <= 1'b1;
                    end
                end
                VISIBLE: begin
                    if (go_out) begin
                        state <= FADE_OUT;
                        fcnt  <= '0;
                        busy  <= 1'b1;
                    end
                end
                FADE_IN: begin
                    if (go_out) begin
                        state <= FADE_OUT;
                        fcnt  <= '0;
                    end else if (step) begin
                        fcnt <= '0;
                        if (level >= 5'd15) begin
                            level <= 5'd16;
                            state <= VISIBLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            level <= level + 5'd1;
                        end
                    end else if (vsync_pulse) begin
                        fcnt <= fcnt + CW'(1);
                    end
                end
                FADE_OUT: begin
                    if (go_in) begin
                        state <= FADE_IN;
                        fcnt  <= '0;
                    end else if (step) begin
                        fcnt <= '0;
                        if (level <= 5'd1) begin
                            level <= 5'd0;
                            state <= BLACK;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            level <= level - 5'd1;
                        end
                    end else if (vsync_pulse) begin
                        fcnt <= fcnt + CW'(1);
                    end
                end
                default: begin
                    state <= BLACK;
                    level <= 5'd0;
                    fcnt  <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Register the scaled colour, one cycle after the index.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            red   <= 4'd0;
            green <= 4'd0;
            blue  <= 4'd0;
        end else begin
            red   <= nr;
            green <= ng;
            blue  <= nb;
        end
    end

endmodule

// File: tb/tb_menu_fade_ctrl.sv
// tb_menu_fade_ctrl: self-checking bench for menu_fade_ctrl.
// Colour results flow through a scoreboard queue.
module tb_menu_fade_ctrl;

    logic       Clk;
    logic       Reset;
    logic       vsync_pulse;
    logic       fade_in_req;
    logic       fade_out_req;
    logic [3:0] pix_index;
    logic [3:0] pal_index;
    logic [3:0] pal_red;
    logic [3:0] pal_green;
    logic [3:0] pal_blue;
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
    logic [4:0] level;
    logic       busy;
    logic       done;

    logic [11:0] pal [16];
    logic [11:0] sbq [$];
    logic [11:0] exp_c;
    int          tests;
    int          fails;

    menu_fade_ctrl #(
        .FRAMES_PER_STEP (2),
        .KEY_INDEX       (4'd0)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .vsync_pulse  (vsync_pulse),
        .fade_in_req  (fade_in_req),
        .fade_out_req (fade_out_req),
        .pix_index    (pix_index),
        .pal_index    (pal_index),
        .pal_red      (pal_red),
        .pal_green    (pal_green),
        .pal_blue     (pal_blue),
        .red          (red),
        .green        (green),
        .blue         (blue),
        .level        (level),
        .busy         (busy),
        .done         (done)
    );

    // Palette ROM model, combinational from pal_index.
    assign pal_red   = pal[pal_index][11:8];
    assign pal_green = pal[pal_index][7:4];
    assign pal_blue  = pal[pal_index][3:0];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [11:0] scale(input logic [11:0] c,
                                          input int lvl);
        int r;
        int g;
        int b;
        r = (int'(c[11:8]) * lvl) / 16;
        g = (int'(c[7:4]) * lvl) / 16;
        b = (int'(c[3:0]) * lvl) / 16;
        return {r[3:0], g[3:0], b[3:0]};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse();
        vsync_pulse = 1'b1;
        tick();
        vsync_pulse = 1'b0;
    endtask

    task automatic req_in();
        fade_in_req = 1'b1;
        tick();
        fade_in_req = 1'b0;
    endtask

    task automatic req_out();
        fade_out_req = 1'b1;
        tick();
        fade_out_req = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        tick();
    endtask

    // Drive one index, queue its expected colour, check after the edge.
    task automatic px(input logic [3:0] idx, input logic [11:0] e,
                      input string name);
        pix_index = idx;
        sbq.push_back(e);
        tick();
        exp_c = sbq.pop_front();
        tests++;
        if ({red, green, blue} !== exp_c) begin
            fails++;
            $display("FAIL %s: rgb=%h expected %h",
                     name, {red, green, blue}, exp_c);
        end
    endtask

    task automatic test_reset();
        tests++;
        if ({level, busy, done, red, green, blue} !== 17'd0) begin
            fails++;
            $display("FAIL reset_state: lvl=%0d busy=%b done=%b rgb=%h",
                     level, busy, done, {red, green, blue});
        end
        pix_index = 4'd1;
        req_in();
        for (int i = 0; i < 18; i++) pulse();
        tests++;
        if (level !== 5'd9 || {red, green, blue} !== 12'h310) begin
            fails++;
            $display("FAIL pre_reset: lvl=%0d rgb=%h expected 9 310",
                     level, {red, green, blue});
        end
        #2;
        Reset = 1'b1;
        #1;
        tests++;
        if ({level, busy, done, red, green, blue} !== 17'd0) begin
            fails++;
            $display("FAIL async_reset: lvl=%0d busy=%b rgb=%h",
                     level, busy, {red, green, blue});
        end
        tick();
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        tests++;
        if (level !== 5'd0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_reset: lvl=%0d busy=%b",
                     level, busy);
        end
    endtask

    task automatic test_fade_in();
        int bad;
        do_reset();
        req_in();
        bad = 0;
        for (int i = 1; i <= 32; i++) begin
            pulse();
            if (i < 32 && (busy !== 1'b1 || done !== 1'b0)) bad++;
            if (i == 16) begin
                tests++;
                if (level !== 5'd8) begin
                    fails++;
                    $display("FAIL level_mid: lvl=%0d expected 8", level);
                end
            end
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL busy_during_fade: %0d bad cycles expected 0",
                     bad);
        end
        tests++;
        if (level !== 5'd16 || done !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL fade_in_end: lvl=%0d done=%b busy=%b",
                     level, done, busy);
        end
        tick();
        tests++;
        if (done !== 1'b0 || level !== 5'd16) begin
            fails++;
            $display("FAIL done_pulse: done=%b lvl=%0d", done, level);
        end
    endtask

    task automatic test_datapath();
        px(4'd1, 12'h731, "rgb_lvl16");
        for (int i = 0; i < 16; i++)
            px(4'(i), pal[i], "b2b_lvl16");
        req_out();
        for (int i = 0; i < 16; i++) pulse();
        px(4'd1, 12'h310, "rgb_lvl8");
        for (int i = 15; i >= 0; i--)
            px(4'(i), scale(pal[i], 8), "b2b_lvl8");
        for (int i = 0; i < 16; i++) pulse();
        px(4'd1, 12'h000, "rgb_lvl0");
        px(4'd2, 12'h000, "rgb_lvl0_b");
    endtask

    task automatic test_reversal();
        int bad;
        do_reset();
        req_in();
        for (int i = 0; i < 10; i++) pulse();
        req_out();
        tests++;
        if (level !== 5'd5 || busy !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL reverse: lvl=%0d busy=%b done=%b",
                     level, busy, done);
        end
        bad = 0;
        for (int i = 1; i <= 10; i++) begin
            pulse();
            if (i < 10 && done !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL early_done: %0d cycles expected 0", bad);
        end
        tests++;
        if (level !== 5'd0 || done !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL fade_out_end: lvl=%0d done=%b busy=%b",
                     level, done, busy);
        end
    endtask

    task automatic test_ignored();
        do_reset();
        fade_in_req  = 1'b1;
        fade_out_req = 1'b1;
        tick();
        fade_in_req  = 1'b0;
        fade_out_req = 1'b0;
        for (int i = 0; i < 4; i++) pulse();
        tests++;
        if (busy !== 1'b0 || level !== 5'd0) begin
            fails++;
            $display("FAIL both_req: busy=%b lvl=%0d", busy, level);
        end
        req_out();
        tests++;
        if (busy !== 1'b0 || level !== 5'd0 || done !== 1'b0) begin
            fails++;
            $display("FAIL out_in_black: busy=%b lvl=%0d done=%b",
                     busy, level, done);
        end
        req_in();
        pulse();
        req_in();
        pulse();
        tests++;
        if (level !== 5'd1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL in_during_fade: lvl=%0d expected 1", level);
        end
    endtask

    task automatic test_key();
        do_reset();
        req_in();
        for (int i = 0; i < 8; i++) pulse();
`ifdef MENU_FADE_KEY_BYPASS_EN
        px(4'd0, 12'h2AF, "key_bypass");
`else
        px(4'd0, 12'h023, "key_scaled");
`endif
        px(4'd2, 12'h333, "nonkey_lvl4");
        tests++;
        if (level !== 5'd4) begin
            fails++;
            $display("FAIL level4: lvl=%0d expected 4", level);
        end
    endtask

    initial begin
        tests        = 0;
        fails        = 0;
        Reset        = 1'b1;
        vsync_pulse  = 1'b0;
        fade_in_req  = 1'b0;
        fade_out_req = 1'b0;
        pix_index    = 4'd0;
        for (int i = 0; i < 16; i++) pal[i] = 12'($urandom);
        pal[0] = 12'h2AF;
        pal[1] = 12'h731;
        pal[2] = 12'hEFF;
        tick();
        tick();
        Reset = 1'b0;
        tick();
        test_reset();
        test_fade_in();
        test_datapath();
        test_reversal();
        test_ignored();
        test_key();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
